// File: rtl/led_ddr_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
//  led_ddr_pattern_gen_pkg
//  Shared types and mode encodings for the DDR LED pattern generator.
//  Revision: 1.0  initial release
// ============================================================================
package led_ddr_pattern_gen_pkg;

    `include "led_pattern_defs.vh"

    // Ramp direction of the breathing duty cycle
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Direction to take after the current step, given the value just reached
    function automatic dir_e next_dir(input dir_e dir, input logic at_top, input logic at_bottom);
        dir_e v_dir;
        v_dir = dir;
        if ((dir == DIR_UP) && at_top) begin
            v_dir = DIR_DOWN;
        end else if ((dir == DIR_DOWN) && at_bottom) begin
            v_dir = DIR_UP;
        end
        return v_dir;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ODDR.sv
`default_nettype none
// ============================================================================
//  ODDR
//  Behavioural model of the vendor output DDR register (Q0 = D0 while CLK is
//  high, D1 while CLK is low; Q1 mirrors the tristate control TX). Used for
//  simulation; the vendor primitive replaces it in the implementation flow.
//  Revision: 1.0  initial release
// ============================================================================
module ODDR (
    output logic Q0,
    output logic Q1,
    input  logic D0,
    input  logic D1,
    input  logic TX,
    input  logic CLK
);

    logic r_d0;
    logic r_d1;

    // Capture both half-cycle bits on the rising edge
    always_ff @(posedge CLK) begin
        r_d0 <= D0;
        r_d1 <= D1;
    end

    assign Q0 = CLK ? r_d0 : r_d1;
    assign Q1 = TX;

endmodule
`default_nettype wire

// File: rtl/led_chan.sv
`default_nettype none
// ============================================================================
//  led_chan
//  One LED channel: blink phase, optional breathing duty ramp, half-slot PWM
//  compare, polarity and the registered D0/D1 bits for the channel's ODDR.
//  Optional feature: LED_BREATHE_EN (breathing duty ramp in PWM mode).
//  Revision: 1.0  initial release
// ============================================================================
module led_chan #(
    parameter int PWM_W          = 8,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_pwm_wrap,
    input  logic [PWM_W-2:0] i_pwm_cnt,
    input  logic [1:0]       i_mode,
    input  logic [PWM_W-1:0] i_duty,
    input  logic             i_breathe,
    output logic             o_d0,
    output logic             o_d1
);

    import led_ddr_pattern_gen_pkg::*;

    logic             r_phase;
    logic [PWM_W-1:0] w_duty_eff;
    logic             w_r0;
    logic             w_r1;

    // Blink phase flips on every prescaler tick, independent of the mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
        end else if (i_tick) begin
            r_phase <= ~r_phase;
        end
    end

`ifdef LED_BREATHE_EN
    localparam logic [PWM_W-1:0] c_duty_max = '1;

    logic [PWM_W-1:0] r_bduty;
    dir_e             r_dir;
    logic             w_at_top;
    logic             w_at_bottom;

    assign w_at_top    = (r_bduty == c_duty_max);
    assign w_at_bottom = (r_bduty == '0);

    // Triangle ramp stepped once per PWM period; each endpoint lasts one period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bduty <= '0;
            r_dir   <= DIR_UP;
        end else if (i_pwm_wrap) begin
            r_dir <= next_dir(r_dir, w_at_top, w_at_bottom);
            if (((r_dir == DIR_UP) && !w_at_top) || ((r_dir == DIR_DOWN) && w_at_bottom)) begin
                r_bduty <= r_bduty + 1'b1;
            end else begin
                r_bduty <= r_bduty - 1'b1;
            end
        end
    end

    assign w_duty_eff = i_breathe ? r_bduty : i_duty;
`else
    logic w_unused;

    assign w_unused   = i_breathe ^ i_pwm_wrap;
    assign w_duty_eff = i_duty;
`endif

    // Raw half-cycle bits for the selected mode
    always_comb begin
        w_r0 = 1'b0;
        w_r1 = 1'b0;
        case (i_mode)
            MODE_ON: begin
                w_r0 = 1'b1;
                w_r1 = 1'b1;
            end
            MODE_BLINK: begin
                w_r0 = r_phase;
                w_r1 = r_phase;
            end
            MODE_PWM: begin
                w_r0 = ({i_pwm_cnt, 1'b0} < w_duty_eff);
                w_r1 = ({i_pwm_cnt, 1'b1} < w_duty_eff);
            end
            default: begin
                w_r0 = 1'b0;
                w_r1 = 1'b0;
            end
        endcase
    end

    // Register the bits with pin polarity applied; reset leaves the LED dark
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_d0 <= LED_ACTIVE_LOW;
            o_d1 <= LED_ACTIVE_LOW;
        end else begin
            o_d0 <= w_r0 ^ LED_ACTIVE_LOW;
            o_d1 <= w_r1 ^ LED_ACTIVE_LOW;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_defs.vh
`default_nettype none
// ============================================================================
//  led_pattern_defs.vh
//  Per-channel LED mode encodings shared by the pattern generator and its
//  channel slices.
//  Revision: 1.0  initial release
// ============================================================================
`ifndef LED_PATTERN_DEFS_VH
`define LED_PATTERN_DEFS_VH

localparam logic [1:0] MODE_OFF   = 2'd0;
localparam logic [1:0] MODE_ON    = 2'd1;
localparam logic [1:0] MODE_BLINK = 2'd2;
localparam logic [1:0] MODE_PWM   = 2'd3;

`endif
`default_nettype wire

// File: rtl/led_ddr_pattern_gen.sv
`default_nettype none
// ============================================================================
//  led_ddr_pattern_gen
//  Multi-channel LED pattern generator: shared prescaler and PWM counter,
//  one led_chan slice plus one ODDR per channel.
//  Optional feature: LED_BREATHE_EN (breathing duty ramp in PWM mode).
//  Revision: 1.0  initial release
// ============================================================================
module led_ddr_pattern_gen #(
    parameter int CHANNELS       = 4,
    parameter int CTR_W          = 26,
    parameter int PWM_W          = 8,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4:0]                div_sel,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [PWM_W*CHANNELS-1:0] duty,
    input  logic [CHANNELS-1:0]       breathe,
    output logic [CHANNELS-1:0]       led_d0,
    output logic [CHANNELS-1:0]       led_d1,
    output logic [CHANNELS-1:0]       led
);

    logic [CTR_W-1:0]    r_ctr;
    logic [CTR_W-1:0]    w_mask;
    int                  w_sel;
    logic                w_tick;
    logic [PWM_W-2:0]    r_pwm_cnt;
    logic                w_wrap;
    logic [CHANNELS-1:0] w_q1_unused;

    // Low-bit mask for the selected tick period; oversize selects clamp to the full counter
    always_comb begin
        w_sel  = int'(div_sel);
        w_mask = '0;
        if (w_sel >= CTR_W) begin
            w_sel = CTR_W - 1;
        end
        for (int j = 0; j < CTR_W; j++) begin
            if (j <= w_sel) begin
                w_mask[j] = 1'b1;
            end
        end
    end

    assign w_tick = en & ((r_ctr & w_mask) == w_mask);
    assign w_wrap = w_tick & (&r_pwm_cnt);

    // Free-running prescaler, frozen while disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctr <= '0;
        end else if (en) begin
            r_ctr <= r_ctr + 1'b1;
        end
    end

    // Shared PWM slot counter, advanced once per tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_chan #(
            .PWM_W          (PWM_W),
            .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_tick     (w_tick),
            .i_pwm_wrap (w_wrap),
            .i_pwm_cnt  (r_pwm_cnt),
            .i_mode     (mode[2*i +: 2]),
            .i_duty     (duty[PWM_W*i +: PWM_W]),
            .i_breathe  (breathe[i]),
            .o_d0       (led_d0[i]),
            .o_d1       (led_d1[i])
        );

        ODDR u_oddr (
            .Q0  (led[i]),
            .Q1  (w_q1_unused[i]),
            .D0  (led_d0[i]),
            .D1  (led_d1[i]),
            .TX  (1'b0),
            .CLK (clk)
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_ddr_pattern_gen.sv
`default_nettype none
// ============================================================================
//  tb_led_ddr_pattern_gen
//  Directed bench for led_ddr_pattern_gen (2 channels, 8-bit prescaler,
//  4-bit duty, active-high pins). Breathe ramp checks need LED_BREATHE_EN.
//  Revision: 1.0  initial release
// ============================================================================
module tb_led_ddr_pattern_gen;

    import led_ddr_pattern_gen_pkg::*;

    localparam int CH = 2;
    localparam int CW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [4:0]    div_sel;
    logic [2*CH-1:0]  mode;
    logic [PW*CH-1:0] duty;
    logic [CH-1:0] breathe;
    logic [CH-1:0] led_d0;
    logic [CH-1:0] led_d1;
    logic [CH-1:0] led;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_ddr_pattern_gen #(
        .CHANNELS       (CH),
        .CTR_W          (CW),
        .PWM_W          (PW),
        .LED_ACTIVE_LOW (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_sel (div_sel),
        .mode    (mode),
        .duty    (duty),
        .breathe (breathe),
        .led_d0  (led_d0),
        .led_d1  (led_d1),
        .led     (led)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count lit half-slots of one channel over 16 consecutive samples
    task automatic count_window(input int ch, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n0 += int'(led_d0[ch]);
            n1 += int'(led_d1[ch]);
        end
    endtask

    typedef struct {
        int         adv;    // prescaler ticks to run (div_sel=0) before applying
        logic [1:0] m0;
        logic [1:0] m1;
        logic [3:0] du0;
        logic [3:0] du1;
        logic [1:0] e_d0;
        logic [1:0] e_d1;
    } vec_t;

    vec_t vecs[9];

    // Hard bound on run length
    initial begin
        repeat (6000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n0, n1, last0, last1, n_tog0, n_tog1, k, n_chg;
        logic prev0, prev1, held, found;

        // pwm_cnt / phase tracked by hand: reset -> cnt 0, phase 0
        vecs[0] = '{0, MODE_ON,    MODE_OFF,   4'd0,  4'd0,  2'b01, 2'b01}; // cnt0 ph0
        vecs[1] = '{0, MODE_BLINK, MODE_ON,    4'd0,  4'd0,  2'b10, 2'b10}; // cnt0 ph0
        vecs[2] = '{1, MODE_BLINK, MODE_BLINK, 4'd0,  4'd0,  2'b11, 2'b11}; // cnt1 ph1
        vecs[3] = '{0, MODE_PWM,   MODE_PWM,   4'd5,  4'd2,  2'b01, 2'b01}; // 2,3 vs 5 / 2
        vecs[4] = '{1, MODE_PWM,   MODE_PWM,   4'd5,  4'd15, 2'b11, 2'b10}; // cnt2: 4,5
        vecs[5] = '{0, MODE_BLINK, MODE_PWM,   4'd0,  4'd0,  2'b00, 2'b00}; // ph0, duty0
        vecs[6] = '{5, MODE_PWM,   MODE_BLINK, 4'd15, 4'd0,  2'b11, 2'b10}; // cnt7 ph1
        vecs[7] = '{1, MODE_PWM,   MODE_OFF,   4'd1,  4'd0,  2'b00, 2'b00}; // wrap cnt0
        vecs[8] = '{0, MODE_PWM,   MODE_PWM,   4'd8,  4'd9,  2'b11, 2'b11}; // cnt0

        // cnt0, duty 1: half-slot 0 lit, half-slot 1 dark
        vecs[7].e_d0 = 2'b01;

        rst_n   = 1'b0;
        en      = 1'b0;
        div_sel = 5'd0;
        mode    = {MODE_ON, MODE_ON};
        duty    = '0;
        breathe = '0;

        // Reset overrides an ON request
        repeat (2) @(negedge clk);
        check("reset_d0", 32'(led_d0), 32'd0);
        check("reset_d1", 32'(led_d1), 32'd0);
        rst_n = 1'b1;

        // Table: advance counters, freeze, apply modes, compare one cycle later
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].adv > 0) begin
                en = 1'b1;
                repeat (2 * vecs[i].adv) @(negedge clk);
                en = 1'b0;
            end
            mode = {vecs[i].m1, vecs[i].m0};
            duty = {vecs[i].du1, vecs[i].du0};
            @(negedge clk);
            check($sformatf("vec%0d_d0", i), 32'(led_d0), 32'(vecs[i].e_d0));
            check($sformatf("vec%0d_d1", i), 32'(led_d1), 32'(vecs[i].e_d1));
        end

        // ODDR pin: D0 while clk high, D1 while clk low (cnt0, ch0 duty1, ch1 ON)
        mode = {MODE_ON, MODE_PWM};
        duty = {4'd0, 4'd1};
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        check("pin_high_half", 32'(led), 32'b11);
        @(negedge clk);
        #1;
        check("pin_low_half", 32'(led), 32'b10);

        // Blink with div_sel=1: both bits toggle every 4 cycles
        mode    = {MODE_OFF, MODE_BLINK};
        div_sel = 5'd1;
        @(negedge clk);
        prev0  = led_d0[0];
        prev1  = led_d1[0];
        last0  = -1;
        last1  = -1;
        n_tog0 = 0;
        n_tog1 = 0;
        en     = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led_d0[0] != prev0) begin
                if (last0 >= 0) check("blink_period_d0", 32'(c - last0), 32'd4);
                last0 = c;
                n_tog0++;
                prev0 = led_d0[0];
            end
            if (led_d1[0] != prev1) begin
                if (last1 >= 0) check("blink_period_d1", 32'(c - last1), 32'd4);
                last1 = c;
                n_tog1++;
                prev1 = led_d1[0];
            end
        end
        check("blink_toggles_d0", 32'(n_tog0 >= 9), 32'd1);
        check("blink_toggles_d1", 32'(n_tog1 >= 9), 32'd1);
        check("blink_d0_d1_align", 32'(last0), 32'(last1));

        // Freeze right after a toggle; outputs still follow mode changes
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (led_d0[0] != prev0) found = 1'b1;
            prev0 = led_d0[0];
        end
        check("blink_resync", 32'(found), 32'd1);
        en    = 1'b0;
        mode  = {MODE_ON, MODE_BLINK};
        held  = led_d0[0];
        n_chg = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chg += int'(led_d0[0] != held);
        end
        check("freeze_hold", 32'(n_chg), 32'd0);
        check("freeze_follow_mode", 32'(led_d0[1]), 32'd1);
        en    = 1'b1;
        k     = 0;
        found = 1'b0;
        for (int c = 1; c <= 10 && !found; c++) begin
            @(negedge clk);
            if (led_d0[0] != held) begin
                found = 1'b1;
                k     = c;
            end
        end
        check("resume_interval", 32'(k), 32'd4);

        // PWM windows on ch1 (div_sel=0: one full period = 16 cycles)
        div_sel = 5'd0;
        mode    = {MODE_PWM, MODE_OFF};
        duty    = {4'd5, 4'd0};
        repeat (2) @(negedge clk);
        count_window(1, n0, n1);
        check("pwm5_d0", 32'(n0), 32'd6);
        check("pwm5_d1", 32'(n1), 32'd4);
        duty = {4'd0, 4'd0};
        repeat (2) @(negedge clk);
        count_window(1, n0, n1);
        check("pwm0_d0", 32'(n0), 32'd0);
        check("pwm0_d1", 32'(n1), 32'd0);
        duty = {4'd15, 4'd0};
        repeat (2) @(negedge clk);
        count_window(1, n0, n1);
        check("pwm15_d0", 32'(n0), 32'd16);
        check("pwm15_d1", 32'(n1), 32'd14);

`ifdef LED_BREATHE_EN
        // Breathe ramp on ch0: window w aligned to PWM periods from reset release
        rst_n   = 1'b0;
        en      = 1'b1;
        mode    = {MODE_OFF, MODE_PWM};
        duty    = {4'd0, 4'd9};
        breathe = 2'b01;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 32; w++) begin
            int exp_b;
            exp_b = (w <= 15) ? w : ((w <= 30) ? (30 - w) : (w - 30));
            count_window(0, n0, n1);
            check($sformatf("breathe_w%0d", w), 32'(n0 + n1), 32'(2 * exp_b));
        end
        // Reset mid-period restarts the ramp at 0, counting up
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            count_window(0, n0, n1);
            check($sformatf("breathe_rst_w%0d", w), 32'(n0 + n1), 32'(2 * w));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
